// File: rtl/cdc_fifo_src_arbiter.sv
// Packet-atomic round-robin arbiter that feeds one CDC FIFO source port from NumIn requesters.
// Each beat carries the winning requester index; the grant is held from first to last beat.
module cdc_fifo_src_arbiter #(
    parameter int NumIn    = 4,
    parameter int WIDTH    = 32,
    parameter int MaxBeats = 16,
    parameter int IdxWidth = $clog2(NumIn),
    parameter int CntWidth = $clog2(MaxBeats + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic [NumIn*WIDTH-1:0] inp_data_i,
    input  logic [NumIn-1:0]       inp_last_i,
    input  logic [NumIn-1:0]       inp_valid_i,
    output logic [NumIn-1:0]       inp_ready_o,
    output logic [WIDTH-1:0]       oup_data_o,
    output logic [IdxWidth-1:0]    oup_idx_o,
    output logic                   oup_last_o,
    output logic                   oup_valid_o,
    input  logic                   oup_ready_i,
    output logic                   busy_o,
    output logic                   len_err_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    localparam logic [IdxWidth-1:0] LastIdx    = IdxWidth'(NumIn - 1);
    localparam logic [CntWidth-1:0] MaxCnt     = CntWidth'(MaxBeats);
    localparam logic [CntWidth:0]   MaxCntExt  = (CntWidth + 1)'(MaxBeats);
    localparam logic [CntWidth:0]   OneCntExt  = (CntWidth + 1)'(1);

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;
    logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;
    logic                  len_err_q, len_err_d;

    logic [IdxWidth-1:0]   grant_idx;
    logic                  grant_found;
    logic [IdxWidth-1:0]   sel_idx;
    logic                  sel_active;
    logic                  sel_valid;
    logic                  handshake;
    logic                  len_violation;

    // Explicit compare-and-wrap keeps non-power-of-two NumIn inside the legal index range.
    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + IdxWidth'(1);
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NumIn; k++) begin
            for (int i = 0; i < NumIn; i++) begin
                if (!grant_found && inp_valid_i[i] &&
                    (i == (int'(rr_ptr_q) + k) % NumIn)) begin
                    grant_found = 1'b1;
                    grant_idx   = IdxWidth'(i);
                end
            end
        end
    end

    // Once locked only lock_idx is forwarded, so a waiting beat cannot change under backpressure.
    always_comb begin
        sel_idx     = (state_q == LOCKED) ? lock_idx_q : grant_idx;
        sel_active  = (state_q == LOCKED) || grant_found;
        oup_data_o  = '0;
        oup_last_o  = 1'b0;
        sel_valid   = 1'b0;
        inp_ready_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (sel_active && (sel_idx == IdxWidth'(i))) begin
                oup_data_o     = inp_data_i[i*WIDTH +: WIDTH];
                oup_last_o     = inp_last_i[i];
                sel_valid      = inp_valid_i[i];
                inp_ready_o[i] = oup_ready_i;
            end
        end
        oup_idx_o   = sel_active ? sel_idx : '0;
        oup_valid_o = sel_valid;
    end

    assign handshake     = oup_valid_o & oup_ready_i;
    assign len_violation = handshake & ~oup_last_o &
                           (({1'b0, beat_cnt_q} + OneCntExt) >= MaxCntExt);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q | len_violation;
        unique case (state_q)
            IDLE: begin
                if (oup_valid_o) begin
                    if (handshake && oup_last_o) begin
                        rr_ptr_d = next_idx(grant_idx);
                    end else begin
                        state_d    = LOCKED;
                        lock_idx_d = grant_idx;
                        beat_cnt_d = handshake ? CntWidth'(1) : '0;
                    end
                end
            end
            LOCKED: begin
                if (handshake) begin
                    if (oup_last_o) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_idx(lock_idx_q);
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q != MaxCnt) begin
                        beat_cnt_d = beat_cnt_q + CntWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // clr_i takes priority over any handshake in the same cycle; the beat still leaves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else if (clr_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign busy_o    = (state_q == LOCKED);
    assign len_err_o = len_err_q;

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed table-driven bench for cdc_fifo_src_arbiter: a 4-input instance with MaxBeats = 4
// and a 3-input instance for the non-power-of-two wrap.
module tb_cdc_fifo_src_arbiter;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        ready;
        logic        clr;
        logic        exp_valid;
        logic [1:0]  exp_idx;
        logic        exp_last;
        logic [3:0]  exp_iready;
        logic        exp_busy;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic [127:0] inp_data;
    logic [3:0]   inp_last = '0;
    logic [3:0]   inp_valid = '0;
    logic [3:0]   inp_ready;
    logic [31:0]  oup_data;
    logic [1:0]   oup_idx;
    logic         oup_last;
    logic         oup_valid;
    logic         oup_ready = 1'b0;
    logic         busy;
    logic         len_err;

    logic [23:0]  inp_data3;
    logic [2:0]   inp_last3 = '0;
    logic [2:0]   inp_valid3 = '0;
    logic [2:0]   inp_ready3;
    logic [7:0]   oup_data3;
    logic [1:0]   oup_idx3;
    logic         oup_last3;
    logic         oup_valid3;
    logic         oup_ready3 = 1'b0;
    logic         busy3;
    logic         len_err3;

    int checks = 0;
    int errors = 0;
    vec_t vecs[30];

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic r,
                                input logic c, input logic ev, input logic [1:0] ei,
                                input logic el, input logic [3:0] er, input logic eb,
                                input logic ee);
        vec_t t;
        t.valid = v; t.last = l; t.ready = r; t.clr = c;
        t.exp_valid = ev; t.exp_idx = ei; t.exp_last = el; t.exp_iready = er;
        t.exp_busy = eb; t.exp_err = ee;
        t.exp_data = ev ? pat(int'(ei)) : 32'h0;
        return t;
    endfunction

    assign inp_data  = {pat(3), pat(2), pat(1), pat(0)};
    assign inp_data3 = {8'hA2, 8'hA1, 8'hA0};

    cdc_fifo_src_arbiter #(.NumIn(4), .WIDTH(32), .MaxBeats(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .inp_data_i(inp_data), .inp_last_i(inp_last), .inp_valid_i(inp_valid),
        .inp_ready_o(inp_ready), .oup_data_o(oup_data), .oup_idx_o(oup_idx),
        .oup_last_o(oup_last), .oup_valid_o(oup_valid), .oup_ready_i(oup_ready),
        .busy_o(busy), .len_err_o(len_err)
    );

    cdc_fifo_src_arbiter #(.NumIn(3), .WIDTH(8), .MaxBeats(16)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0),
        .inp_data_i(inp_data3), .inp_last_i(inp_last3), .inp_valid_i(inp_valid3),
        .inp_ready_o(inp_ready3), .oup_data_o(oup_data3), .oup_idx_o(oup_idx3),
        .oup_last_o(oup_last3), .oup_valid_o(oup_valid3), .oup_ready_i(oup_ready3),
        .busy_o(busy3), .len_err_o(len_err3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        inp_valid = v.valid;
        inp_last  = v.last;
        oup_ready = v.ready;
        clr       = v.clr;
        #1;
    endtask

    task automatic checkVector(input int n, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", n);
        checkOutput({tag, " valid"}, 32'(oup_valid), 32'(v.exp_valid));
        checkOutput({tag, " idx"},   32'(oup_idx),   32'(v.exp_idx));
        checkOutput({tag, " last"},  32'(oup_last),  32'(v.exp_last));
        checkOutput({tag, " ready"}, 32'(inp_ready), 32'(v.exp_iready));
        checkOutput({tag, " busy"},  32'(busy),      32'(v.exp_busy));
        checkOutput({tag, " err"},   32'(len_err),   32'(v.exp_err));
        checkOutput({tag, " data"},  oup_data,       v.exp_data);
    endtask

    initial begin
        // fairness: all valid, single-beat packets
        vecs[0]  = mk(4'hF, 4'hF, 1, 0, 1, 0, 1, 4'b0001, 0, 0);
        vecs[1]  = mk(4'hF, 4'hF, 1, 0, 1, 1, 1, 4'b0010, 0, 0);
        vecs[2]  = mk(4'hF, 4'hF, 1, 0, 1, 2, 1, 4'b0100, 0, 0);
        vecs[3]  = mk(4'hF, 4'hF, 1, 0, 1, 3, 1, 4'b1000, 0, 0);
        vecs[4]  = mk(4'hF, 4'hF, 1, 0, 1, 0, 1, 4'b0001, 0, 0);
        vecs[5]  = mk(4'hF, 4'hF, 1, 0, 1, 1, 1, 4'b0010, 0, 0);
        // atomicity: req1 three beats while req0/req2 wait
        vecs[6]  = mk(4'h2, 4'h0, 1, 0, 1, 1, 0, 4'b0010, 0, 0);
        vecs[7]  = mk(4'h7, 4'h0, 1, 0, 1, 1, 0, 4'b0010, 1, 0);
        vecs[8]  = mk(4'h7, 4'h2, 1, 0, 1, 1, 1, 4'b0010, 1, 0);
        vecs[9]  = mk(4'h5, 4'h5, 1, 0, 1, 2, 1, 4'b0100, 0, 0);
        vecs[10] = mk(4'h5, 4'h5, 1, 0, 1, 0, 1, 4'b0001, 0, 0);
        // stall on req3, req0 raised during the stall
        vecs[11] = mk(4'h8, 4'h8, 0, 0, 1, 3, 1, 4'b0000, 0, 0);
        vecs[12] = mk(4'h8, 4'h8, 0, 0, 1, 3, 1, 4'b0000, 1, 0);
        vecs[13] = mk(4'h8, 4'h8, 0, 0, 1, 3, 1, 4'b0000, 1, 0);
        vecs[14] = mk(4'h8, 4'h8, 0, 0, 1, 3, 1, 4'b0000, 1, 0);
        vecs[15] = mk(4'h9, 4'h9, 0, 0, 1, 3, 1, 4'b0000, 1, 0);
        vecs[16] = mk(4'h9, 4'h9, 1, 0, 1, 3, 1, 4'b1000, 1, 0);
        vecs[17] = mk(4'h1, 4'h1, 1, 0, 1, 0, 1, 4'b0001, 0, 0);
        // length error: req2 sends six beats with MaxBeats = 4
        vecs[18] = mk(4'h4, 4'h0, 1, 0, 1, 2, 0, 4'b0100, 0, 0);
        vecs[19] = mk(4'h4, 4'h0, 1, 0, 1, 2, 0, 4'b0100, 1, 0);
        vecs[20] = mk(4'h4, 4'h0, 1, 0, 1, 2, 0, 4'b0100, 1, 0);
        vecs[21] = mk(4'h4, 4'h0, 1, 0, 1, 2, 0, 4'b0100, 1, 0);
        vecs[22] = mk(4'h5, 4'h0, 1, 0, 1, 2, 0, 4'b0100, 1, 1);
        vecs[23] = mk(4'h5, 4'h4, 1, 0, 1, 2, 1, 4'b0100, 1, 1);
        vecs[24] = mk(4'h0, 4'h0, 1, 0, 0, 0, 0, 4'b0000, 0, 1);
        vecs[25] = mk(4'h0, 4'h0, 1, 1, 0, 0, 0, 4'b0000, 0, 1);
        vecs[26] = mk(4'h0, 4'h0, 1, 0, 0, 0, 0, 4'b0000, 0, 0);
        // clear together with a handshake drops the lock
        vecs[27] = mk(4'h2, 4'h0, 1, 0, 1, 1, 0, 4'b0010, 0, 0);
        vecs[28] = mk(4'h3, 4'h0, 1, 1, 1, 1, 0, 4'b0010, 1, 0);
        vecs[29] = mk(4'h3, 4'h3, 1, 0, 1, 0, 1, 4'b0001, 0, 0);

        #1;
        checkOutput("reset valid", 32'(oup_valid), 32'h0);
        checkOutput("reset idx",   32'(oup_idx),   32'h0);
        checkOutput("reset data",  oup_data,       32'h0);
        checkOutput("reset ready", 32'(inp_ready), 32'h0);
        checkOutput("reset busy",  32'(busy),      32'h0);
        checkOutput("reset err",   32'(len_err),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 30; n++) begin
            applyStimulus(vecs[n]);
            checkVector(n, vecs[n]);
        end

        // async reset while req1 is locked after two beats
        applyStimulus(mk(4'h2, 4'h0, 1, 0, 1, 1, 0, 4'b0010, 0, 0));
        applyStimulus(mk(4'h2, 4'h0, 1, 0, 1, 1, 0, 4'b0010, 1, 0));
        checkOutput("prereset busy", 32'(busy), 32'h1);
        @(negedge clk);
        inp_valid = 4'h3;
        inp_last  = 4'h3;
        oup_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("async rst busy",  32'(busy),      32'h0);
        checkOutput("async rst idx",   32'(oup_idx),   32'h0);
        checkOutput("async rst ready", 32'(inp_ready), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        oup_ready = 1'b1;
        #1;
        checkOutput("post rst idx",   32'(oup_idx),   32'h0);
        checkOutput("post rst ready", 32'(inp_ready), 32'h1);
        checkOutput("post rst data",  oup_data,       pat(0));
        @(negedge clk);
        inp_valid = '0;
        oup_ready = 1'b0;

        // three-input instance: round robin must wrap 2 -> 0
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            inp_valid3 = 3'b111;
            inp_last3  = 3'b111;
            oup_ready3 = 1'b1;
            #1;
            checkOutput($sformatf("n3 idx%0d", n),   32'(oup_idx3),   32'(n % 3));
            checkOutput($sformatf("n3 ready%0d", n), 32'(inp_ready3), 32'(3'b001 << (n % 3)));
            checkOutput($sformatf("n3 data%0d", n),  32'(oup_data3),  32'(8'hA0 + 8'(n % 3)));
        end
        @(negedge clk);
        inp_valid3 = '0;
        oup_ready3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
